// File: rtl/param_uart_tx.sv
// Parameter-readback UART transmitter: snapshots the pulse parameters on request and sends a
// 20-byte frame (sync, 18 payload bytes, checksum). Define PARAM_UART_TX_PARITY_EN for 8E1.
module param_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic [7:0]  nut_w,
  input  logic [15:0] nut_d,
  input  logic [7:0]  cp,
  input  logic [7:0]  p_bl,
  input  logic [15:0] p_bl_off,
  input  logic        bl,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] CntMax   = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  LastByte = 5'd19;
  localparam logic [4:0]  CsumByte = 5'd19;

`ifdef PARAM_UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e         state_q, state_d;
  logic [15:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [4:0]     byte_idx_q, byte_idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [143:0]   payload_q, payload_d;
  logic [7:0]     csum_q, csum_d;
  logic           txd_q, txd_d;
  logic           done_q, done_d;
  logic           tick;

  assign tick = (bit_cnt_q == CntMax);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    payload_d  = payload_q;
    csum_d     = csum_q;
    done_d     = 1'b0;

    if (state_q != StIdle) begin
      bit_cnt_d = tick ? 16'd0 : bit_cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        // The done cycle itself never accepts a request.
        if (send && !done_q) begin
          state_d    = StStart;
          bit_cnt_d  = 16'd0;
          byte_idx_d = 5'd0;
          shreg_d    = SYNC_BYTE;
          csum_d     = 8'd0;
          payload_d  = {per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, 7'b0, bl};
        end
      end
      StStart: begin
        if (tick) begin
          bit_idx_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef PARAM_UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef PARAM_UART_TX_PARITY_EN
      StParity: begin
        if (tick) state_d = StStop;
      end
`endif
      StStop: begin
        if (tick) begin
          if (byte_idx_q == LastByte) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d    = StStart;
            byte_idx_d = byte_idx_q + 5'd1;
            // Payload drains MSB byte first; checksum covers every payload byte as it loads.
            if (byte_idx_d == CsumByte) begin
              shreg_d = csum_q;
            end else begin
              shreg_d   = payload_q[143:136];
              payload_d = {payload_q[135:0], 8'h00};
              csum_d    = csum_q + payload_q[143:136];
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // txd is registered from next-state values so the line is glitch-free.
    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shreg_d[bit_idx_d];
`ifdef PARAM_UART_TX_PARITY_EN
      StParity: txd_d = ^shreg_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 5'd0;
      shreg_q    <= 8'd0;
      payload_q  <= '0;
      csum_q     <= 8'd0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      payload_q  <= payload_d;
      csum_q     <= csum_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_param_uart_tx.sv
// Bench for param_uart_tx: frame-level reference model checked every cycle on two instances
// (4 and 2 clocks per bit), plus literal decoded-frame expectations.
module tb_param_uart_tx;

`ifdef PARAM_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FB = NB * 20;

  typedef logic [7:0] frame_t [20];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send4 = 1'b0, send2 = 1'b0;
  logic [31:0] per = '0;
  logic [15:0] p1wid = '0, del = '0, p2wid = '0, nut_d = '0, p_bl_off = '0;
  logic [7:0]  nut_w = '0, cp = '0, p_bl = '0;
  logic        bl = 1'b0;
  logic        txd4, busy4, done4, txd2, busy2, done2;

  int asserts = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_uart_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut4 (
    .clk(clk), .reset(reset), .send(send4), .per(per), .p1wid(p1wid), .del(del),
    .p2wid(p2wid), .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off),
    .bl(bl), .txd(txd4), .busy(busy4), .done(done4)
  );

  param_uart_tx #(.CLKS_PER_BIT(2), .SYNC_BYTE(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .send(send2), .per(per), .p1wid(p1wid), .del(del),
    .p2wid(p2wid), .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off),
    .bl(bl), .txd(txd2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic frame_t build_frame();
    frame_t f;
    int s;
    f[0] = 8'hA5;
    {f[1], f[2], f[3], f[4]} = per;
    {f[5], f[6]} = p1wid;
    {f[7], f[8]} = del;
    {f[9], f[10]} = p2wid;
    f[11] = nut_w;
    {f[12], f[13]} = nut_d;
    f[14] = cp;
    f[15] = p_bl;
    {f[16], f[17]} = p_bl_off;
    f[18] = {7'b0, bl};
    s = 0;
    for (int i = 1; i <= 18; i++) s += int'(f[i]);
    f[19] = s[7:0];
    return f;
  endfunction

  // Line level of frame bit b (bit 0 of each byte slot is the start bit).
  function automatic logic exp_bit(frame_t f, int b);
    int k, p;
    k = b / NB;
    p = b % NB;
    if (p == 0) return 1'b0;
    if (p <= 8) return f[k][p-1];
    if (p == NB - 1) return 1'b1;
    return ^f[k];
  endfunction

  // Reference model: per-instance frame position in clock cycles since the first txd low.
  int     cpb [2] = '{4, 2};
  logic   m_act [2] = '{1'b0, 1'b0};
  logic   m_done [2] = '{1'b0, 1'b0};
  int     m_t [2] = '{0, 0};
  frame_t m_frame [2];

  initial forever begin
    @(posedge clk or negedge reset);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_act[i] = 1'b0;
        m_done[i] = 1'b0;
        m_t[i] = 0;
      end else begin
        logic pd, s;
        pd = m_done[i];
        s = (i == 1) ? send2 : send4;
        m_done[i] = 1'b0;
        if (m_act[i]) begin
          m_t[i]++;
          if (m_t[i] == FB * cpb[i]) begin
            m_act[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end else if (s && !pd) begin
          m_frame[i] = build_frame();
          m_act[i] = 1'b1;
          m_t[i] = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("txd4", txd4, m_act[0] ? exp_bit(m_frame[0], m_t[0] / 4) : 1'b1);
    chk("busy4", busy4, m_act[0]);
    chk("done4", done4, m_done[0]);
    chk("txd2", txd2, m_act[1] ? exp_bit(m_frame[1], m_t[1] / 2) : 1'b1);
    chk("busy2", busy2, m_act[1]);
    chk("done2", done2, m_done[1]);
  end

  function automatic logic txd_of(bit sel);
    return sel ? txd2 : txd4;
  endfunction

  function automatic logic done_of(bit sel);
    return sel ? done2 : done4;
  endfunction

  // Mid-bit UART decoder; returns on the negedge where done is seen (offset from first low).
  task automatic rx_frame(input bit sel, output frame_t by, output logic par [20],
                          output int done_off);
    int c, cur, k;
    c = sel ? 2 : 4;
    cur = 0;
    k = 0;
    done_off = -1;
    for (int i = 0; i < 20; i++) begin
      by[i] = 8'h00;
      par[i] = 1'b0;
    end
    while (txd_of(sel) !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      chk("rx_start_timeout", 32'd1, 32'd0);
      return;
    end
    for (int b = 0; b < FB; b++) begin
      int tgt, p;
      tgt = b * c + c / 2;
      while (cur < tgt) begin
        @(negedge clk);
        cur++;
      end
      p = b % NB;
      if (p >= 1 && p <= 8) by[b / NB][p-1] = txd_of(sel);
      if (NB == 11 && p == 9) par[b / NB] = txd_of(sel);
    end
    while (cur < FB * c + 8) begin
      @(negedge clk);
      cur++;
      if (done_of(sel) === 1'b1) begin
        done_off = cur;
        break;
      end
    end
  endtask

  task automatic set_test1();
    per = 32'd4000; p1wid = 16'd30; del = 16'd200; p2wid = 16'd60; nut_w = 8'd0;
    nut_d = 16'd0; cp = 8'd1; p_bl = 8'd50; p_bl_off = 16'd100; bl = 1'b1;
  endtask

  task automatic pulse_send4();
    @(negedge clk);
    send4 = 1'b1;
    @(negedge clk);
    send4 = 1'b0;
  endtask

  frame_t exp1;
  frame_t expmax;
  frame_t got;
  logic   par [20];
  int     doff;
  int     k;

  initial begin
    exp1 = '{8'hA5, 8'h00, 8'h00, 8'h0F, 8'hA0, 8'h00, 8'h1E, 8'h00, 8'hC8, 8'h00,
             8'h3C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h32, 8'h00, 8'h64, 8'h01, 8'h69};
    expmax[0] = 8'hA5;
    for (int i = 1; i <= 17; i++) expmax[i] = 8'hFF;
    expmax[18] = 8'h01;
    expmax[19] = 8'hF0;

    // Reset values.
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd4, 1'b1);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_txd", txd4, 1'b1);

    // Test 1: nominal frame.
    set_test1();
    pulse_send4();
    rx_frame(1'b0, got, par, doff);
    for (int i = 0; i < 20; i++) chk($sformatf("t1_byte%0d", i), got[i], exp1[i]);
    chk("t1_done_offset", doff, FB * 4);
`ifdef PARAM_UART_TX_PARITY_EN
    chk("t6_par_A5", par[0], 1'b0);
    chk("t6_par_0F", par[3], 1'b0);
    chk("t6_par_A0", par[4], 1'b0);
    chk("t6_par_C8", par[8], 1'b1);
    chk("t6_len", doff, 880);
`else
    chk("t1_len", doff, 800);
`endif
    repeat (3) @(negedge clk);

    // Test 2: abort in byte 7, then a clean restart.
    pulse_send4();
    repeat (7 * NB * 4 + 6) @(negedge clk);
    chk("t2_busy_mid", busy4, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("t2_abort_txd", txd4, 1'b1);
    chk("t2_abort_busy", busy4, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_abort_done", done4, 1'b0);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_idle_txd", txd4, 1'b1);
    pulse_send4();
    rx_frame(1'b0, got, par, doff);
    for (int i = 0; i < 20; i++) chk($sformatf("t2_byte%0d", i), got[i], exp1[i]);
    repeat (3) @(negedge clk);

    // Test 3: send held through a frame; next frame only after the done cycle.
    @(negedge clk);
    send4 = 1'b1;
    rx_frame(1'b0, got, par, doff);
    chk("t3_sync", got[0], 8'hA5);
    chk("t3_csum", got[19], 8'h69);
    chk("t3_done_offset", doff, FB * 4);
    @(negedge clk);
    chk("t3_gap_txd", txd4, 1'b1);
    chk("t3_gap_busy", busy4, 1'b0);
    @(negedge clk);
    chk("t3_restart_txd", txd4, 1'b0);
    chk("t3_restart_busy", busy4, 1'b1);
    send4 = 1'b0;
    k = 0;
    while (busy4 !== 1'b0 && k < FB * 4 + 20) begin
      @(negedge clk);
      k++;
    end
    chk("t3_second_end", k < FB * 4 + 20, 1'b1);
    repeat (3) @(negedge clk);

    // Test 4: parameters changed right after acceptance are not sent.
    pulse_send4();
    per = 32'hDEADBEEF;
    rx_frame(1'b0, got, par, doff);
    for (int i = 0; i < 20; i++) chk($sformatf("t4_byte%0d", i), got[i], exp1[i]);
    repeat (3) @(negedge clk);

    // Test 5: all fields at maximum, checksum wrap, 2 clocks per bit.
    per = 32'hFFFFFFFF; p1wid = 16'hFFFF; del = 16'hFFFF; p2wid = 16'hFFFF; nut_w = 8'hFF;
    nut_d = 16'hFFFF; cp = 8'hFF; p_bl = 8'hFF; p_bl_off = 16'hFFFF; bl = 1'b1;
    @(negedge clk);
    send2 = 1'b1;
    @(negedge clk);
    send2 = 1'b0;
    rx_frame(1'b1, got, par, doff);
    for (int i = 0; i < 20; i++) chk($sformatf("t5_byte%0d", i), got[i], expmax[i]);
    chk("t5_done_offset", doff, FB * 2);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
